// File: rtl/injector_pulse_scheduler.sv
// rtl/injector_pulse_scheduler.sv - four-channel injector pulse scheduler with per-channel pulse timing
module injector_pulse_scheduler #(
    parameter int TICK_DIV = 50,
    parameter int PW_MAX   = 20000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_trigger,
    input  logic        i_pw_wr,
    input  logic [1:0]  i_pw_sel,
    input  logic [15:0] i_pw_data,
    input  logic        i_cut,
    input  logic        i_err_clr,
    output logic [3:0]  o_enable,
    output logic [3:0]  o_busy,
    output logic [3:0]  o_retrig_err
);

    localparam logic [0:0]  ST_IDLE    = 1'b0;
    localparam logic [0:0]  ST_ACTIVE  = 1'b1;
    localparam logic [9:0]  PRESC_LAST = 10'(TICK_DIV - 1);
    localparam logic [15:0] PW_CLAMP   = 16'(PW_MAX);

    logic [3:0][0:0]  state_q, state_d;
    logic [3:0][9:0]  presc_q, presc_d;
    logic [3:0][15:0] cnt_q,   cnt_d;
    logic [3:0][15:0] pw_q,    pw_d;
    logic [3:0]       err_q,   err_d;

    logic [15:0] pw_wr_val;

    // Clamp the incoming pulse width once; shared by all channels.
    always_comb begin
        pw_wr_val = (i_pw_data > PW_CLAMP) ? PW_CLAMP : i_pw_data;
    end

    // Per-channel next-state: pulse-width register, FSM, prescaler, working count, sticky error.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        cnt_d   = cnt_q;
        pw_d    = pw_q;
        err_d   = err_q;
        for (int n = 0; n < 4; n++) begin
            // A write only changes the register; a running pulse keeps its latched count.
            if (i_pw_wr && (i_pw_sel == 2'(n))) begin
                pw_d[n] = pw_wr_val;
            end

            // Clear first so that a same-edge set below takes precedence.
            if (i_err_clr) begin
                err_d[n] = 1'b0;
            end

            if (state_q[n] == ST_ACTIVE) begin
                // Retrigger while active never restarts the pulse, only flags it.
                if (i_trigger[n]) begin
                    err_d[n] = 1'b1;
                end
                if (i_cut) begin
                    state_d[n] = ST_IDLE;
                    presc_d[n] = '0;
                    cnt_d[n]   = '0;
                end else if (presc_q[n] == PRESC_LAST) begin
                    presc_d[n] = '0;
                    if (cnt_q[n] == 16'd1) begin
                        state_d[n] = ST_IDLE;
                        cnt_d[n]   = '0;
                    end else begin
                        cnt_d[n] = cnt_q[n] - 16'd1;
                    end
                end else begin
                    presc_d[n] = presc_q[n] + 10'd1;
                end
            end else begin
                // Uses the old register value, so a same-edge write affects only later pulses.
                if (i_trigger[n] && !i_cut && (pw_q[n] != 16'd0)) begin
                    state_d[n] = ST_ACTIVE;
                    presc_d[n] = '0;
                    cnt_d[n]   = pw_q[n];
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= '0;
            presc_q <= '0;
            cnt_q   <= '0;
            pw_q    <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            pw_q    <= pw_d;
            err_q   <= err_d;
        end
    end

    // Enables come straight from the state flops, so they are glitch-free.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            o_enable[n] = (state_q[n] == ST_ACTIVE);
            o_busy[n]   = (state_q[n] == ST_ACTIVE);
        end
        o_retrig_err = err_q;
    end

endmodule

// File: tb/tb_injector_pulse_scheduler.sv
// tb/tb_injector_pulse_scheduler.sv - directed self-checking bench for injector_pulse_scheduler
module tb_injector_pulse_scheduler;

    logic        i_clk;
    logic        i_rst_n;
    logic [3:0]  i_trigger;
    logic        i_pw_wr;
    logic [1:0]  i_pw_sel;
    logic [15:0] i_pw_data;
    logic        i_cut;
    logic        i_err_clr;
    logic [3:0]  o_enable;
    logic [3:0]  o_busy;
    logic [3:0]  o_retrig_err;

    int tests_run;
    int tests_failed;

    injector_pulse_scheduler #(
        .TICK_DIV(4),
        .PW_MAX  (100)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_trigger   (i_trigger),
        .i_pw_wr     (i_pw_wr),
        .i_pw_sel    (i_pw_sel),
        .i_pw_data   (i_pw_data),
        .i_cut       (i_cut),
        .i_err_clr   (i_err_clr),
        .o_enable    (o_enable),
        .o_busy      (o_busy),
        .o_retrig_err(o_retrig_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge, then drop all one-cycle strobes.
    task automatic tick();
        @(posedge i_clk);
        #1;
        i_trigger = 4'h0;
        i_pw_wr   = 1'b0;
        i_err_clr = 1'b0;
    endtask

    task automatic write_pw(input logic [1:0] ch, input logic [15:0] pw);
        i_pw_wr   = 1'b1;
        i_pw_sel  = ch;
        i_pw_data = pw;
        tick();
    endtask

    // Called just after the triggering edge; counts high cycles and busy/enable disagreement.
    task automatic measure(input int ch, input int retrig_at, output int n, output int busy_bad);
        n = 0;
        busy_bad = 0;
        for (int k = 0; k < 1000; k++) begin
            if (o_busy[ch] !== o_enable[ch]) busy_bad++;
            if (!o_enable[ch]) break;
            n++;
            if (n == retrig_at) i_trigger[ch] = 1'b1;
            tick();
        end
    endtask

    initial begin
        int n;
        int bb;
        int cnt [4];
        tests_run    = 0;
        tests_failed = 0;
        i_rst_n   = 1'b0;
        i_trigger = 4'h0;
        i_pw_wr   = 1'b0;
        i_pw_sel  = 2'd0;
        i_pw_data = 16'd0;
        i_cut     = 1'b0;
        i_err_clr = 1'b0;
        #22;
        check("reset_enable", 32'(o_enable), 32'h0);
        check("reset_busy", 32'(o_busy), 32'h0);
        check("reset_err", 32'(o_retrig_err), 32'h0);
        i_rst_n = 1'b1;
        #1;

        // Basic pulse: pw=5 -> 20 cycles.
        write_pw(2'd0, 16'd5);
        i_trigger = 4'h1;
        tick();
        check("ch0_en_after_trig", 32'(o_enable[0]), 32'd1);
        measure(0, 0, n, bb);
        check("ch0_pw5_len", 32'(n), 32'd20);
        check("ch0_busy_tracks", 32'(bb), 32'd0);

        // Clamp: 500 -> 100 -> 400 cycles.
        write_pw(2'd2, 16'd500);
        i_trigger = 4'h4;
        tick();
        measure(2, 0, n, bb);
        check("ch2_clamp_len", 32'(n), 32'd400);
        // Zero pulse width: no pulse, no error.
        write_pw(2'd2, 16'd0);
        i_trigger = 4'h4;
        tick();
        check("ch2_pw0_en", 32'(o_enable[2]), 32'd0);
        check("ch2_pw0_err", 32'(o_retrig_err[2]), 32'd0);

        // Retrigger: pulse unchanged, sticky error set.
        write_pw(2'd1, 16'd10);
        i_trigger = 4'h2;
        tick();
        measure(1, 8, n, bb);
        check("ch1_retrig_len", 32'(n), 32'd40);
        check("ch1_retrig_err", 32'(o_retrig_err[1]), 32'd1);
        i_err_clr = 1'b1;
        tick();
        check("ch1_err_clr", 32'(o_retrig_err[1]), 32'd0);
        i_trigger = 4'h2;
        tick();
        i_trigger = 4'h2;
        i_err_clr = 1'b1;
        tick();
        check("ch1_set_wins", 32'(o_retrig_err[1]), 32'd1);
        i_cut = 1'b1;
        tick();
        i_cut = 1'b0;
        i_err_clr = 1'b1;
        tick();

        // All channels at once: 4/8/12/16 cycles.
        write_pw(2'd0, 16'd1);
        write_pw(2'd1, 16'd2);
        write_pw(2'd2, 16'd3);
        write_pw(2'd3, 16'd4);
        i_trigger = 4'hF;
        tick();
        for (int c = 0; c < 4; c++) cnt[c] = 0;
        for (int k = 0; k < 20; k++) begin
            for (int c = 0; c < 4; c++) if (o_enable[c]) cnt[c]++;
            tick();
        end
        check("all_ch0_len", 32'(cnt[0]), 32'd4);
        check("all_ch1_len", 32'(cnt[1]), 32'd8);
        check("all_ch2_len", 32'(cnt[2]), 32'd12);
        check("all_ch3_len", 32'(cnt[3]), 32'd16);

        // Cut at cycle 6 ends all pulses and blocks a concurrent trigger.
        i_trigger = 4'hF;
        tick();
        for (int k = 1; k < 6; k++) tick();
        check("pre_cut_en", 32'(o_enable), 32'hE);
        i_cut = 1'b1;
        i_trigger = 4'hF;
        tick();
        check("cut_en", 32'(o_enable), 32'h0);
        check("cut_busy", 32'(o_busy), 32'h0);
        i_trigger = 4'hF;
        tick();
        i_cut = 1'b0;
        tick();
        check("cut_trig_ignored", 32'(o_enable), 32'h0);

        // Write during active pulse: 24 now, 12 next.
        write_pw(2'd3, 16'd6);
        i_trigger = 4'h8;
        tick();
        i_pw_wr   = 1'b1;
        i_pw_sel  = 2'd3;
        i_pw_data = 16'd3;
        measure(3, 0, n, bb);
        check("ch3_running_len", 32'(n), 32'd24);
        i_trigger = 4'h8;
        tick();
        measure(3, 0, n, bb);
        check("ch3_next_len", 32'(n), 32'd12);
        // Trigger and write on the same edge use the old width.
        i_trigger = 4'h8;
        i_pw_wr   = 1'b1;
        i_pw_sel  = 2'd3;
        i_pw_data = 16'd7;
        tick();
        measure(3, 0, n, bb);
        check("ch3_same_edge_old", 32'(n), 32'd12);
        i_trigger = 4'h8;
        tick();
        measure(3, 0, n, bb);
        check("ch3_same_edge_new", 32'(n), 32'd28);

        // Asynchronous reset mid-pulse.
        write_pw(2'd0, 16'd5);
        i_trigger = 4'h1;
        tick();
        tick();
        tick();
        #2;
        i_rst_n = 1'b0;
        #1;
        check("async_rst_en", 32'(o_enable), 32'h0);
        check("async_rst_busy", 32'(o_busy), 32'h0);
        #3;
        i_rst_n = 1'b1;
        i_trigger = 4'h1;
        tick();
        check("post_rst_pw_zero", 32'(o_enable), 32'h0);
        write_pw(2'd1, 16'd2);
        i_trigger = 4'h2;
        tick();
        measure(1, 0, n, bb);
        check("post_rst_pulse", 32'(n), 32'd8);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/injector_pulse_scheduler.md
INJECTOR_PULSE_SCHEDULER -- requirements
Module: injector_pulse_scheduler

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50, giving clock cycles per pulse-width unit (1 us at 50 MHz); legal range 2..1023.
REQ-002 The block SHALL have parameter PW_MAX, default 20000, giving the pulse-width clamp in units.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single system clock; all logic is rising-edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port i_trigger, input, 4 bits: one-cycle start-of-injection strobe, one bit per injector.
REQ-006 The block SHALL have port i_pw_wr, input, 1 bit: pulse-width write strobe.
REQ-007 The block SHALL have port i_pw_sel, input, 2 bits: injector index for the write.
REQ-008 The block SHALL have port i_pw_data, input, 16 bits: pulse width in units.
REQ-009 The block SHALL have port i_cut, input, 1 bit: level-sensitive fuel cut for all injectors.
REQ-010 The block SHALL have port i_err_clr, input, 1 bit: clears the sticky error flags.
REQ-011 The block SHALL have port o_enable, output, 4 bits: per-injector enable, driving the i_enable inputs of the injector driver system.
REQ-012 The block SHALL have port o_busy, output, 4 bits: per-channel ACTIVE indication.
REQ-013 The block SHALL have port o_retrig_err, output, 4 bits: sticky flag, trigger received while the channel is ACTIVE.

Function
REQ-014 Each channel SHALL hold a 16-bit pulse-width register; a write with i_pw_wr=1 SHALL load min(i_pw_data, PW_MAX) into the channel selected by i_pw_sel on that edge.
REQ-015 Each channel SHALL implement an FSM with states IDLE and ACTIVE.
REQ-016 IDLE->ACTIVE: on an edge with i_trigger[n]=1, i_cut=0 and the pulse-width register nonzero, the channel SHALL latch the register into a working count.
REQ-017 On entry to ACTIVE the channel SHALL reset its private prescaler to 0, and o_enable[n] SHALL go high on that same edge, one cycle of latency from the trigger.
REQ-018 In ACTIVE, the prescaler SHALL count 0..TICK_DIV-1 and wrap; at each wrap the working count SHALL decrement.
REQ-019 When the working count would reach 0, the channel SHALL return to IDLE and drop o_enable[n], so the high time is exactly pw*TICK_DIV cycles.
REQ-020 A trigger on a channel whose pulse-width register is 0 SHALL be ignored and SHALL produce no pulse and no error.
REQ-021 A pulse-width write during ACTIVE SHALL not alter the running pulse and SHALL take effect on the next trigger.
REQ-022 A trigger and a write to the same channel on the same edge SHALL start the pulse with the old pulse width.
REQ-023 A trigger while ACTIVE SHALL be ignored, SHALL not extend or restart the pulse, and SHALL set o_retrig_err[n].
REQ-024 i_cut=1 SHALL force all channels to IDLE and all o_enable bits low on the next edge, and SHALL block new triggers while asserted.
REQ-025 When i_cut and a trigger occur on the same edge, the cut SHALL win.
REQ-026 i_err_clr SHALL clear all o_retrig_err bits.
REQ-027 When i_err_clr and an error set occur on the same edge, the set SHALL win.
REQ-028 Pulse-width registers SHALL not be affected by i_cut or i_err_clr.
REQ-029 o_busy[n] SHALL equal (state==ACTIVE); o_enable SHALL be registered and glitch-free.
REQ-030 The four channels SHALL operate independently, including simultaneous triggers on all four channels.

Reset
REQ-031 i_rst_n=0 SHALL asynchronously force o_enable=0, o_busy=0, o_retrig_err=0, all FSMs to IDLE, all prescalers and working counts to 0, and all pulse-width registers to 0.
REQ-032 A reset asserted mid-pulse SHALL drop the enable immediately, without waiting for a clock edge.
REQ-033 After reset release, the block SHALL accept a write and a trigger on the first edge.

Verification (TICK_DIV=4, PW_MAX=100)
REQ-034 Write ch0 pw=5, trigger ch0 -> o_enable[0] high on the next edge for exactly 20 cycles, then low; o_busy[0] tracks it.
REQ-035 Write ch2 pw=500 -> reads back clamped, and a trigger gives 400 cycles high; pw=0 plus trigger -> no pulse, no error.
REQ-036 ch1 pw=10 triggered, retrigger at cycle 8 -> pulse still ends at 40 cycles and o_retrig_err[1]=1; i_err_clr -> 0; clear plus a retrigger on the same edge -> stays 1.
REQ-037 All four channels triggered together with pw 1,2,3,4 -> pulses of 4/8/12/16 cycles; i_cut asserted at cycle 6 -> all enables low on the next edge, and a trigger during the cut is ignored.
REQ-038 Write ch3 pw=3 during an active pw=6 pulse -> current pulse 24 cycles, next pulse 12 cycles.
REQ-039 Assert i_rst_n low mid-pulse -> o_enable low asynchronously; after release, pulse-width registers are 0 and a trigger produces no pulse.
